mb_rtu_frame_timer: RTL and testbench
=====================================

Name: mb_rtu_frame_timer

Overview:
Modbus RTU receive-side frame delimiter, and the parametrised successor of the single 3.5T idle detector. Measures inter-character silence after each received byte against both the t1.5 and the t3.5 limits, and generates frame start/end strobes. Flags frames that violate the t1.5 inter-character rule, and reports frame length in bytes. Sits between the UART byte receiver and the RTU frame parser/CRC checker.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- BAUD_RATE, 9600: line baud rate.
- CHAR_BITS, 11: bits per character (start + 8 data + parity/stop).
- FIXED_ABOVE, 19200: baud threshold above which the fixed Modbus timings apply (750 us / 1750 us).
- CNT_W, 20: gap counter width; must hold T35_CYC.
- LEN_W, 9: byte-count width; the count saturates at 2^LEN_W-1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous reset, active-high.
- clr, input, 1: synchronous abort; forces IDLE and clears the counters and flags.
- rx_busy, input, 1: level signal, high while the receiver is inside a character (from start bit detection to rx_done).
- rx_done, input, 1: one-cycle pulse indicating a byte was received.
- frame_start, output, 1: one-cycle pulse on the first byte of a frame.
- frame_end, output, 1: one-cycle pulse when t3.5 silence completes a frame.
- frame_ok, output, 1: valid with frame_end; 1 means no t1.5 violation occurred.
- frame_len, output, LEN_W: byte count of the frame; valid with frame_end and held until the next frame_end.
- gap_err, output, 1: one-cycle pulse when a character starts after t1.5 but before t3.5.
- line_idle, output, 1: level signal, high in the IDLE state.

Behaviour:
- Timing constants:
  - BIT_CYC = CLK_FREQ/BAUD_RATE.
  - If BAUD_RATE <= FIXED_ABOVE: T15_CYC = 15*CHAR_BITS*BIT_CYC/10 and T35_CYC = 35*CHAR_BITS*BIT_CYC/10.
  - Otherwise: T15_CYC = (CLK_FREQ/1000)*750/1000 and T35_CYC = (CLK_FREQ/1000)*1750/1000.
  - All arithmetic is elaboration-time integer arithmetic, truncating.
- Reset: state=IDLE, line_idle=1; every other output 0; frame_len=0; internal cnt=0, byte_cnt=0, err=0.
- States:
  - IDLE: rx_busy is ignored. On rx_done: pulse frame_start; byte_cnt=1, err=0, cnt=0; go to GAP15.
  - GAP15: cnt++ each cycle. If rx_busy, go to RECV. Else if cnt==T15_CYC-1, go to GAP35.
  - GAP35: cnt++ each cycle. If rx_busy: pulse gap_err, set err=1, go to RECV. Else if cnt==T35_CYC-1: pulse frame_end, drive frame_ok=~err, latch frame_len=byte_cnt, go to IDLE.
  - RECV: cnt is held. On rx_done: byte_cnt++ (saturating), cnt=0, go to GAP15.
- Priority and simultaneous events:
  - rx_done beats rx_busy in every state.
  - rx_busy beats counter expiry in GAP15 and GAP35; a character starting on the T35 cycle is still a gap error and not a new frame.
  - rx_done received in GAP15/GAP35 without rx_busy (malformed receiver) is handled as in RECV. If it arrives in GAP35, also pulse gap_err and set err=1.
- frame_end latency: frame_end is high during the cycle that begins T35_CYC rising edges after the edge that sampled the last rx_done, assuming no rx_busy in between.
- All outputs are registered; pulses last exactly one cycle.
- clr has priority over all inputs except rst. It returns the block to IDLE and clears cnt, byte_cnt and err. No pulse fires on the clr cycle; frame_len holds its value.
- Reset mid-frame: return immediately to the reset values. No frame_end is emitted for the aborted frame.
- The byte counter saturates at 2^LEN_W-1 and never wraps.

Decomposition:
- Package mb_rtu_pkg holds:
  - the state enum (IDLE, GAP15, GAP35, RECV);
  - constant functions t15_cycles(clk, baud, bits) and t35_cycles(clk, baud, bits);
  - the 750/1750 us constants, shared with the TX-side inter-frame delay.
- One sub-module, mb_gap_cnt: a CNT_W counter with clear, enable, and compare outputs hit15/hit35. The top holds the FSM, byte counter and output registers.

Test Plan:
All tests use CLK_FREQ=1000000 and BAUD_RATE=10000, giving T15=1650 and T35=3850, unless stated otherwise.
- Three bytes, with a 500-cycle gap between rx_done and the next rx_busy -> one frame_start on byte 1; frame_end exactly 3850 cycles after the third rx_done; frame_ok=1, frame_len=3; gap_err is never asserted.
- Second byte starts 2000 cycles after the first rx_done -> gap_err pulse at cycle 2000; frame continues; frame_end gives frame_ok=0, frame_len=2.
- rx_busy rises exactly at cnt==3849 -> gap_err pulse, no frame_end, no frame_start; the next rx_done increments the byte count.
- BAUD_RATE=38400 -> T15=750, T35=1750; a one-byte frame ends with frame_end 1750 cycles after rx_done.
- LEN_W=3 with 10 back-to-back bytes -> frame_len=7 (saturated).
- rst asserted at gap cycle 1000, or clr pulsed mid-frame -> line_idle=1 and no frame_end. The next rx_done produces frame_start, and that frame's frame_len counts only bytes after the abort.

Source files
------------

// File: rtl/mb_rtu_pkg.sv
// Shared Modbus RTU timing definitions: FSM state encoding and the
// t1.5 / t3.5 silence limits converted to clock cycles.
package mb_rtu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP15 = 2'd1,
    GAP35 = 2'd2,
    RECV  = 2'd3
  } state_t;

  // Fixed Modbus silences used above 19200 baud; the TX-side
  // inter-frame delay uses the same figures.
  localparam int T15_US          = 750;
  localparam int T35_US          = 1750;
  localparam int FIXED_ABOVE_DEF = 19200;

  function automatic int t15_cycles(input int clk, input int baud, input int bits,
                                    input int fixed_above = FIXED_ABOVE_DEF);
    int bit_cyc;
    bit_cyc = clk / baud;
    if (baud <= fixed_above) return (15 * bits * bit_cyc) / 10;
    else                     return ((clk / 1000) * T15_US) / 1000;
  endfunction

  function automatic int t35_cycles(input int clk, input int baud, input int bits,
                                    input int fixed_above = FIXED_ABOVE_DEF);
    int bit_cyc;
    bit_cyc = clk / baud;
    if (baud <= fixed_above) return (35 * bits * bit_cyc) / 10;
    else                     return ((clk / 1000) * T35_US) / 1000;
  endfunction

endpackage

// File: rtl/mb_rtu_frame_timer_gap_cnt.sv
// Inter-character silence counter. hit15/hit35 flag the last cycle of the
// t1.5 / t3.5 windows so the FSM can act on the following edge.
module mb_gap_cnt #(
  parameter int CNT_W   = 20,
  parameter int T15_CYC = 1650,
  parameter int T35_CYC = 3850
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit15,
  output logic hit35
);

  logic [CNT_W-1:0] cnt;

  // Count silence cycles; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CNT_W'(1);
  end

  assign hit15 = (cnt == CNT_W'(T15_CYC - 1));
  assign hit35 = (cnt == CNT_W'(T35_CYC - 1));

endmodule

// File: rtl/mb_rtu_frame_timer.sv
// Modbus RTU receive frame delimiter: watches silence between received
// bytes, emits frame start/end strobes, flags t1.5 violations and reports
// the saturating byte count of each frame.
//
// state | meaning
// IDLE  | line silent, no frame in progress
// GAP15 | after a byte, silence shorter than t1.5
// GAP35 | silence past t1.5; a new character now is a gap error
// RECV  | a character is being received inside the frame
module mb_rtu_frame_timer
  import mb_rtu_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int CHAR_BITS   = 11,
  parameter int FIXED_ABOVE = 19200,
  parameter int CNT_W       = 20,
  parameter int LEN_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             rx_busy,
  input  logic             rx_done,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_ok,
  output logic [LEN_W-1:0] frame_len,
  output logic             gap_err,
  output logic             line_idle
);

  localparam int T15_CYC = t15_cycles(CLK_FREQ, BAUD_RATE, CHAR_BITS, FIXED_ABOVE);
  localparam int T35_CYC = t35_cycles(CLK_FREQ, BAUD_RATE, CHAR_BITS, FIXED_ABOVE);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] byte_cnt, byte_nxt, byte_inc;
  logic             err, err_nxt;
  logic             cnt_clr, cnt_en;
  logic             hit15, hit35;
  logic             start_nxt, end_nxt, gerr_nxt;

  mb_gap_cnt #(
    .CNT_W  (CNT_W),
    .T15_CYC(T15_CYC),
    .T35_CYC(T35_CYC)
  ) u_gap_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .hit15(hit15),
    .hit35(hit35)
  );

  // Byte count saturates instead of wrapping.
  assign byte_inc = (byte_cnt == '1) ? byte_cnt : byte_cnt + LEN_W'(1);

  // State, byte counter and violation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_nxt;
      err      <= err_nxt;
    end
  end

  // Next-state decode; rx_done beats rx_busy, rx_busy beats counter expiry.
  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_cnt;
    err_nxt   = err;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    gerr_nxt  = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
      byte_nxt  = '0;
      err_nxt   = 1'b0;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr = 1'b1;
          if (rx_done) begin
            start_nxt = 1'b1;
            byte_nxt  = LEN_W'(1);
            err_nxt   = 1'b0;
            state_nxt = GAP15;
          end
        end
        GAP15: begin
          if (rx_done) begin
            // Receiver skipped rx_busy: treat as a completed character.
            byte_nxt  = byte_inc;
            cnt_clr   = 1'b1;
            state_nxt = GAP15;
          end else if (rx_busy) begin
            state_nxt = RECV;
          end else begin
            cnt_en = 1'b1;
            if (hit15) state_nxt = GAP35;
          end
        end
        GAP35: begin
          if (rx_done) begin
            byte_nxt  = byte_inc;
            cnt_clr   = 1'b1;
            gerr_nxt  = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = GAP15;
          end else if (rx_busy) begin
            gerr_nxt  = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = RECV;
          end else if (hit35) begin
            end_nxt   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_en = 1'b1;
          end
        end
        RECV: begin
          if (rx_done) begin
            byte_nxt  = byte_inc;
            cnt_clr   = 1'b1;
            state_nxt = GAP15;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end
      endcase
    end
  end

  // Registered outputs; frame_ok/frame_len update only on frame completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      gap_err     <= 1'b0;
      frame_ok    <= 1'b0;
      frame_len   <= '0;
      line_idle   <= 1'b1;
    end else begin
      frame_start <= start_nxt;
      frame_end   <= end_nxt;
      gap_err     <= gerr_nxt;
      line_idle   <= (state_nxt == IDLE);
      if (end_nxt) begin
        frame_ok  <= ~err;
        frame_len <= byte_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mb_rtu_frame_timer.sv
// Bench for mb_rtu_frame_timer: three instances (10 kBd, 38.4 kBd, 3-bit
// length) share stimulus; a scoreboard queue holds expected frame_end events.
module tb_mb_rtu_frame_timer;

  logic clk = 1'b0;
  logic rst, clr, rx_busy, rx_done;

  logic       a_fs, a_fe, a_ok, a_ge, a_idle;
  logic [8:0] a_len;
  logic       b_fs, b_fe, b_ok, b_ge, b_idle;
  logic [8:0] b_len;
  logic       c_fs, c_fe, c_ok, c_ge, c_idle;
  logic [2:0] c_len;

  always #5 clk = ~clk;

  mb_rtu_frame_timer #(.CLK_FREQ(1000000), .BAUD_RATE(10000)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .rx_busy(rx_busy), .rx_done(rx_done),
    .frame_start(a_fs), .frame_end(a_fe), .frame_ok(a_ok), .frame_len(a_len),
    .gap_err(a_ge), .line_idle(a_idle));

  mb_rtu_frame_timer #(.CLK_FREQ(1000000), .BAUD_RATE(38400)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .rx_busy(rx_busy), .rx_done(rx_done),
    .frame_start(b_fs), .frame_end(b_fe), .frame_ok(b_ok), .frame_len(b_len),
    .gap_err(b_ge), .line_idle(b_idle));

  mb_rtu_frame_timer #(.CLK_FREQ(1000000), .BAUD_RATE(10000), .LEN_W(3)) dut_c (
    .clk(clk), .rst(rst), .clr(clr), .rx_busy(rx_busy), .rx_done(rx_done),
    .frame_start(c_fs), .frame_end(c_fe), .frame_ok(c_ok), .frame_len(c_len),
    .gap_err(c_ge), .line_idle(c_idle));

  typedef struct { bit ok; int len; int cyc; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int sel = 0;
  int n_starts = 0, n_gerr = 0, last_start = -1, last_gerr = -1;
  int last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer for the selected instance.
  always @(negedge clk) begin
    logic fs, fe, ok, ge;
    int   len;
    exp_t e;
    fs  = (sel == 0) ? a_fs : (sel == 1) ? b_fs : c_fs;
    fe  = (sel == 0) ? a_fe : (sel == 1) ? b_fe : c_fe;
    ok  = (sel == 0) ? a_ok : (sel == 1) ? b_ok : c_ok;
    ge  = (sel == 0) ? a_ge : (sel == 1) ? b_ge : c_ge;
    len = (sel == 0) ? int'(a_len) : (sel == 1) ? int'(b_len) : int'(c_len);
    if (!rst) begin
      if (fs === 1'b1) begin n_starts++; last_start = cyc; end
      if (ge === 1'b1) begin n_gerr++;   last_gerr  = cyc; end
      if (fe === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_frame_end dut=%0d cycle=%0d ok=%0b len=%0d", sel, cyc, ok, len);
        end else begin
          e = exp_q.pop_front();
          if (ok !== e.ok || len !== e.len || cyc !== e.cyc) begin
            n_bad++;
            $display("FAIL frame_end dut=%0d got ok=%0b len=%0d cyc=%0d expected ok=%0b len=%0d cyc=%0d",
                     sel, ok, len, cyc, e.ok, e.len, e.cyc);
          end
        end
      end
    end
  end

  // One character: rx_busy first sampled 'gap' edges after the previous
  // rx_done edge, held 'dur' edges, then rx_done; last_done = sampling edge.
  task automatic send_char(input int gap, input int dur);
    repeat (gap - 1) @(posedge clk);
    #1 rx_busy = 1'b1;
    repeat (dur) begin @(posedge clk); #1; end
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_busy   = 1'b0;
    rx_done   = 1'b0;
    last_done = cyc;
  endtask

  task automatic wait_drain(input int lim, output bit done);
    done = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (exp_q.size() == 0) begin done = 1'b1; break; end
      @(posedge clk);
    end
    if (exp_q.size() == 0) done = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; rx_busy = 1'b0; rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    n_starts = 0; n_gerr = 0; last_start = -1; last_gerr = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; rx_busy = 1'b0; rx_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({a_idle, a_fs, a_fe, a_ok, a_ge} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_flags got=%b expected=10000", {a_idle, a_fs, a_fe, a_ok, a_ge});
    end
    n_cmp++;
    if (a_len !== 9'd0) begin n_bad++; $display("FAIL reset_len got=%0d expected=0", a_len); end
    n_cmp++;
    if ({b_idle, c_idle, c_len} !== 5'b11000) begin
      n_bad++; $display("FAIL reset_bc got=%b expected=11000", {b_idle, c_idle, c_len});
    end
    do_reset();
  endtask

  task automatic test_three_bytes();
    int  d0;
    bit  done;
    sel = 0; do_reset();
    send_char(5, 100);  d0 = last_done;
    send_char(500, 1000);
    send_char(500, 1000);
    exp_q.push_back('{ok: 1'b1, len: 3, cyc: last_done + 3850});
    wait_drain(4000, done);
    @(negedge clk);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL three_bytes_timeout pending=%0d expected=0", exp_q.size()); end
    n_cmp++;
    if (n_starts !== 1 || last_start !== d0) begin
      n_bad++; $display("FAIL three_bytes_start got n=%0d at=%0d expected n=1 at=%0d", n_starts, last_start, d0);
    end
    n_cmp++;
    if (n_gerr !== 0) begin n_bad++; $display("FAIL three_bytes_gap_err got=%0d expected=0", n_gerr); end
  endtask

  task automatic test_gap_err();
    int  d0;
    bit  done;
    sel = 0; do_reset();
    send_char(5, 100);  d0 = last_done;
    send_char(2000, 100);
    @(negedge clk);
    n_cmp++;
    if (n_gerr !== 1 || last_gerr !== d0 + 2000) begin
      n_bad++; $display("FAIL gap_err_pulse got n=%0d at=%0d expected n=1 at=%0d", n_gerr, last_gerr, d0 + 2000);
    end
    exp_q.push_back('{ok: 1'b0, len: 2, cyc: last_done + 3850});
    wait_drain(4000, done);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL gap_err_timeout pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_t35_boundary();
    int  d0;
    bit  done;
    sel = 0; do_reset();
    send_char(5, 100);  d0 = last_done;
    send_char(3850, 40);
    @(negedge clk);
    n_cmp++;
    if (n_gerr !== 1 || last_gerr !== d0 + 3850) begin
      n_bad++; $display("FAIL t35_gap_err got n=%0d at=%0d expected n=1 at=%0d", n_gerr, last_gerr, d0 + 3850);
    end
    exp_q.push_back('{ok: 1'b0, len: 2, cyc: last_done + 3850});
    wait_drain(4000, done);
    @(negedge clk);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL t35_timeout pending=%0d expected=0", exp_q.size()); end
    n_cmp++;
    if (n_starts !== 1) begin n_bad++; $display("FAIL t35_starts got=%0d expected=1", n_starts); end
  endtask

  task automatic test_fast_baud();
    bit done;
    sel = 1; do_reset();
    send_char(5, 30);
    exp_q.push_back('{ok: 1'b1, len: 1, cyc: last_done + 1750});
    wait_drain(2000, done);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL fast_baud_timeout pending=%0d expected=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit done;
    sel = 2; do_reset();
    for (int i = 0; i < 10; i++) send_char(1, 20);
    exp_q.push_back('{ok: 1'b1, len: 7, cyc: last_done + 3850});
    wait_drain(4000, done);
    @(negedge clk);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL b2b_timeout pending=%0d expected=0", exp_q.size()); end
    n_cmp++;
    if (n_gerr !== 0 || n_starts !== 1) begin
      n_bad++; $display("FAIL b2b_pulses got gerr=%0d starts=%0d expected gerr=0 starts=1", n_gerr, n_starts);
    end
  endtask

  task automatic test_abort();
    bit done;
    sel = 0; do_reset();
    send_char(5, 100);
    repeat (999) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (a_idle !== 1'b1 || a_len !== 9'd0) begin
      n_bad++; $display("FAIL rst_abort got idle=%0b len=%0d expected idle=1 len=0", a_idle, a_len);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_starts = 0;
    repeat (4000) @(posedge clk);
    send_char(5, 100);
    send_char(10, 100);
    exp_q.push_back('{ok: 1'b1, len: 2, cyc: last_done + 3850});
    wait_drain(4000, done);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL after_rst_timeout pending=%0d expected=0", exp_q.size()); end
    send_char(5, 100);
    send_char(10, 100);
    repeat (999) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_idle !== 1'b1 || a_len !== 9'd2 || a_fe !== 1'b0) begin
      n_bad++; $display("FAIL clr_abort got idle=%0b len=%0d fe=%0b expected idle=1 len=2 fe=0", a_idle, a_len, a_fe);
    end
    repeat (4000) @(posedge clk);
    send_char(5, 100);
    exp_q.push_back('{ok: 1'b1, len: 1, cyc: last_done + 3850});
    wait_drain(4000, done);
    @(negedge clk);
    n_cmp++;
    if (!done) begin n_bad++; $display("FAIL after_clr_timeout pending=%0d expected=0", exp_q.size()); end
    n_cmp++;
    if (n_starts !== 3) begin n_bad++; $display("FAIL abort_starts got=%0d expected=3", n_starts); end
  endtask

  initial begin
    test_reset();
    test_three_bytes();
    test_gap_err();
    test_t35_boundary();
    test_fast_baud();
    test_back_to_back();
    test_abort();
    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
